// File: rtl/ahb_lite_mem_slave.sv
// ahb_lite_mem_slave: AHB-Lite word memory with byte lanes, wait states, read-only window and ERROR response
module ahb_lite_mem_slave #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned RO_START    = 'h000,
    parameter int unsigned RO_END      = 'h00F,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int unsigned WW      = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH   = 2 ** WW;
    localparam logic [31:0] RO_SPAN = RO_END - RO_START;
    localparam bit          RO_ON   = RO_START <= RO_END;
    localparam logic [2:0]  WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t          state, start_state;
    logic [2:0]      cnt;
    logic [WW-1:0]   a_word;
    logic [1:0]      a_off, a_size;
    logic            a_write, a_err;
    logic            ready_q, resp_q;
    logic            accept, ro_hit, misaligned, err;
    logic [3:0]      be;
    logic [31:0]     mem [DEPTH];

    // Offset compare against the window span avoids an always-true unsigned compare when RO_START is 0
    assign ro_hit      = RO_ON && HWRITE && ((32'(HADDR) - RO_START) <= RO_SPAN);
    assign misaligned  = (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
    assign err         = ro_hit || misaligned || (HSIZE > 3'd2);
    assign accept      = HSEL && HREADY && (HTRANS == 2'b10 || HTRANS == 2'b11) && state != S_WAIT && state != S_ERR1;
    assign start_state = (WAIT_STATES > 0) ? S_WAIT : err ? S_ERR1 : S_DATA;
    assign be          = a_size == 2'd0 ? 4'b0001 << a_off : a_size == 2'd1 ? (a_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign HRDATA      = (state == S_DATA && !a_write) ? mem[a_word] : 32'h0;
    assign HREADYOUT   = ready_q;
    assign HRESP       = resp_q;

    // Transfer FSM: captures the address phase and drives registered HREADYOUT/HRESP for the next cycle
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            ready_q <= 1'b1;
            resp_q  <= 1'b0;
            a_word  <= '0;
            a_off   <= 2'd0;
            a_size  <= 2'd0;
            a_write <= 1'b0;
            a_err   <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (cnt == 3'd0) begin
                        state   <= a_err ? S_ERR1 : S_DATA;
                        ready_q <= !a_err;
                        resp_q  <= a_err;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_ERR1: begin
                    state   <= S_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        state   <= start_state;
                        cnt     <= WS_LOAD;
                        ready_q <= start_state == S_DATA;
                        resp_q  <= start_state == S_ERR1;
                        a_word  <= HADDR[ADDR_WIDTH-1:2];
                        a_off   <= HADDR[1:0];
                        a_size  <= HSIZE[1:0];
                        a_write <= HWRITE;
                        a_err   <= err;
                    end else begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Write commit at the edge ending an OKAY write data phase; erroring transfers never reach S_DATA
    always_ff @(posedge HCLK) begin
        if (state == S_DATA && a_write)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[a_word][8*i +: 8] <= HWDATA[8*i +: 8];
    end
endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// tb_ahb_lite_mem_slave: directed checks of a zero-wait and a three-wait memory slave
module tb_ahb_lite_mem_slave;
    logic        HCLK = 1'b0;
    logic        HRESET, sel0, sel3, hwrite;
    logic [9:0]  haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] hwdata, rdata0, rdata3, d;
    logic        ready0, ready3, resp0, resp3;
    int          checks = 0;
    int          errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_mem_slave #(.WAIT_STATES(0)) d0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ready0),
        .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
    );

    ahb_lite_mem_slave #(.WAIT_STATES(3)) d3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ready3),
        .HRDATA(rdata3), .HREADYOUT(ready3), .HRESP(resp3)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_ne(input string tag, input logic [31:0] obs, input logic [31:0] bad);
        checks++;
        assert (obs !== bad) else begin
            errors++;
            $error("FAIL %s: observed %h must differ from %h", tag, obs, bad);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr(input logic [9:0] a, input logic w, input logic [2:0] s);
        haddr  = a;
        hwrite = w;
        hsize  = s;
        htrans = 2'b10;
    endtask

    task automatic wait3(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk1($sformatf("%s_w%0d_ready", tag, i), ready3, 1'b0);
            chk32($sformatf("%s_w%0d_rdata", tag, i), rdata3, 32'h0);
            cyc();
        end
    endtask

    task automatic wr3(input logic [9:0] a, input logic [2:0] s, input logic [31:0] v);
        addr(a, 1'b1, s);
        cyc();
        htrans = 2'b00;
        hwdata = v;
        repeat (4) cyc();
    endtask

    task automatic rd3(input logic [9:0] a, output logic [31:0] v);
        addr(a, 1'b0, 3'd2);
        cyc();
        htrans = 2'b00;
        repeat (3) cyc();
        v = rdata3;
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        HRESET = 1'b1; sel0 = 1'b1; sel3 = 1'b0;
        haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
        cyc(); cyc();
        chk1("rst_ready", ready0, 1'b1);
        chk1("rst_resp", resp0, 1'b0);
        chk32("rst_rdata", rdata0, 32'h0);
        HRESET = 1'b0;
        cyc();
        chk1("idle_ready", ready0, 1'b1);
        chk1("idle_resp", resp0, 1'b0);

        // word write, byte write, read back with single-cycle data phases
        addr(10'h040, 1'b1, 3'd2);
        cyc();
        chk1("w40_ready", ready0, 1'b1);
        hwdata = 32'hAABBCCDD;
        addr(10'h041, 1'b1, 3'd0);
        cyc();
        chk1("w41_ready", ready0, 1'b1);
        hwdata = 32'h0000_1100;
        addr(10'h040, 1'b0, 3'd2);
        cyc();
        chk32("r40_rdata", rdata0, 32'hAABB11DD);
        chk1("r40_ready", ready0, 1'b1);
        chk1("r40_resp", resp0, 1'b0);
        htrans = 2'b00;
        cyc();
        chk32("idle_rdata", rdata0, 32'h0);

        // write into the read-only window
        addr(10'h004, 1'b1, 3'd2);
        cyc();
        hwdata = 32'hDEADBEEF;
        htrans = 2'b00;
        chk1("ro_e1_ready", ready0, 1'b0);
        chk1("ro_e1_resp", resp0, 1'b1);
        cyc();
        chk1("ro_e2_ready", ready0, 1'b1);
        chk1("ro_e2_resp", resp0, 1'b1);
        addr(10'h004, 1'b0, 3'd2);
        cyc();
        chk1("ro_rd_ready", ready0, 1'b1);
        chk1("ro_rd_resp", resp0, 1'b0);
        chk_ne("ro_rd_rdata", rdata0, 32'hDEADBEEF);
        htrans = 2'b00;
        cyc();

        // misaligned halfword and word writes
        addr(10'h100, 1'b1, 3'd2);
        cyc();
        hwdata = 32'h01020304;
        addr(10'h101, 1'b1, 3'd1);
        cyc();
        hwdata = 32'hFFFFFFFF;
        htrans = 2'b00;
        chk1("mah_e1_ready", ready0, 1'b0);
        chk1("mah_e1_resp", resp0, 1'b1);
        cyc();
        chk1("mah_e2_ready", ready0, 1'b1);
        chk1("mah_e2_resp", resp0, 1'b1);
        addr(10'h102, 1'b1, 3'd2);
        cyc();
        htrans = 2'b00;
        chk1("maw_e1_ready", ready0, 1'b0);
        chk1("maw_e1_resp", resp0, 1'b1);
        cyc();
        chk1("maw_e2_ready", ready0, 1'b1);
        chk1("maw_e2_resp", resp0, 1'b1);
        addr(10'h100, 1'b0, 3'd2);
        cyc();
        chk32("ma_nowrite", rdata0, 32'h01020304);
        htrans = 2'b00;
        cyc();

        // aligned upper halfword write, then an illegal HSIZE
        addr(10'h102, 1'b1, 3'd1);
        cyc();
        chk1("hw_ready", ready0, 1'b1);
        hwdata = 32'hBEEF0000;
        addr(10'h100, 1'b0, 3'd3);
        cyc();
        htrans = 2'b00;
        chk1("sz3_e1_ready", ready0, 1'b0);
        chk1("sz3_e1_resp", resp0, 1'b1);
        cyc();
        chk1("sz3_e2_resp", resp0, 1'b1);
        addr(10'h100, 1'b0, 3'd2);
        cyc();
        chk32("hw_rdata", rdata0, 32'hBEEF0304);
        htrans = 2'b00;
        cyc();

        // pipelined read-after-write
        addr(10'h200, 1'b1, 3'd2);
        cyc();
        chk1("raw_w_ready", ready0, 1'b1);
        hwdata = 32'h12345678;
        addr(10'h200, 1'b0, 3'd2);
        cyc();
        chk1("raw_r_ready", ready0, 1'b1);
        chk32("raw_rdata", rdata0, 32'h12345678);
        htrans = 2'b00;
        cyc();

        // three wait states
        sel0 = 1'b0;
        sel3 = 1'b1;
        cyc();
        wr3(10'h040, 3'd2, 32'hAABBCCDD);
        wr3(10'h041, 3'd0, 32'h0000_1100);
        addr(10'h040, 1'b0, 3'd2);
        cyc();
        htrans = 2'b00;
        wait3("ws_rd");
        chk1("ws_rd_ready", ready3, 1'b1);
        chk32("ws_rd_rdata", rdata3, 32'hAABB11DD);
        cyc();

        addr(10'h080, 1'b1, 3'd2);
        cyc();
        hwdata = 32'h11112222;
        addr(10'h084, 1'b1, 3'd2);
        wait3("b2b0");
        chk1("b2b0_ready", ready3, 1'b1);
        chk1("b2b0_resp", resp3, 1'b0);
        cyc();
        hwdata = 32'h33334444;
        htrans = 2'b00;
        wait3("b2b1");
        chk1("b2b1_ready", ready3, 1'b1);
        cyc();
        rd3(10'h080, d);
        chk32("b2b0_data", d, 32'h11112222);
        rd3(10'h084, d);
        chk32("b2b1_data", d, 32'h33334444);

        // asynchronous reset while a write waits
        wr3(10'h0C0, 3'd2, 32'h0);
        addr(10'h0C0, 1'b1, 3'd2);
        cyc();
        hwdata = 32'hCAFEF00D;
        htrans = 2'b00;
        cyc();
        chk1("mr_pre_ready", ready3, 1'b0);
        #2;
        HRESET = 1'b1;
        #1;
        chk1("mr_ready", ready3, 1'b1);
        chk1("mr_resp", resp3, 1'b0);
        chk32("mr_rdata", rdata3, 32'h0);
        cyc();
        HRESET = 1'b0;
        cyc();
        rd3(10'h0C0, d);
        chk32("mr_nowrite", d, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_lite_mem_slave.md
# ahb_lite_mem_slave

Parametrised AHB-Lite memory slave: the second-generation replacement for the fixed 1 KB slave memory in the verification environment. It adds:
- separated address/data phases with a proper HREADY input;
- byte and halfword writes via HSIZE;
- a programmable number of wait states;
- a configurable read-only window;
- the two-cycle AHB-Lite ERROR response.

It sits behind the decoder/mux, one instance per memory region.

## Interface
Parameters:
- ADDR_WIDTH, 10: byte-address width. Memory holds 2**(ADDR_WIDTH-2) 32-bit words.
- RO_START, 'h000: first byte address of the read-only window (inclusive).
- RO_END, 'h00F: last byte address of the read-only window (inclusive).
- WAIT_STATES, 0: wait cycles inserted before every NONSEQ/SEQ completes. Range 0–7.

Ports:
- HCLK  in  1  clock; all sampling on the rising edge.
- HRESET  in  1  reset; asynchronous, active-high.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  ADDR_WIDTH  byte address (address phase).
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word. Values >2 are illegal.
- HWDATA  in  32  write data (data phase), little-endian lanes.
- HREADY  in  1  bus ready from the mux.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- **Address-phase accept:** HSEL & HREADY & HTRANS[1] at a rising edge.
  - Registers word address HADDR[ADDR_WIDTH-1:2], byte offset HADDR[1:0], HSIZE, HWRITE, and an error flag.
  - HTRANS = IDLE/BUSY, or HSEL = 0: nothing is registered, and the next cycle is a zero-wait OKAY.
- **Error flag** is set if any of the following holds:
  - (HWRITE & RO_START <= HADDR <= RO_END);
  - HSIZE > 2;
  - misalignment: halfword with HADDR[0] = 1, or word with HADDR[1:0] != 0.
- **FSM states:** IDLE, WAIT, ERR1, ERR2, and DATA (completion cycle of an OKAY transfer).
  - IDLE: on accept, go to WAIT if WAIT_STATES > 0. Otherwise go to ERR1 if the error flag is set, else DATA.
  - WAIT: a 3-bit counter loads WAIT_STATES-1 and decrements. At 0, go to ERR1 (error flag) or DATA.
  - DATA: HREADYOUT = 1, HRESP = 0. A new accept in the same cycle re-enters the path above; otherwise go to IDLE.
  - ERR1: HREADYOUT = 0, HRESP = 1. Always go to ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1. A new accept in this cycle is handled as from IDLE.
- **Write commit:** on the rising edge ending a DATA cycle with a registered write, memory is updated from HWDATA on the enabled lanes only.
  - Byte: lane HADDR[1:0].
  - Halfword: lanes {HADDR[1],0} and {HADDR[1],1}.
  - Word: all 4 lanes.
  - Erroring transfers never write.
- **HRDATA:**
  - In a DATA cycle of a read: combinationally the full word at the registered word address, regardless of HSIZE.
  - Every other cycle: 32'h0.
- Memory contents are not reset.

## Timing
- **Reset values:** HREADYOUT = 1, HRESP = 0, HRDATA = 0, FSM in IDLE, counter 0, transfer registers cleared.
- **Reset mid-operation:** HRESET asserted in WAIT/DATA/ERR1/ERR2 aborts the transfer immediately, with no memory write.
- **Latency:** a transfer accepted at edge N completes (HREADYOUT = 1) in the cycle after edge N+WAIT_STATES. An ERROR completes one cycle after that.
- **Pipelining:** back-to-back NONSEQ with WAIT_STATES = 0 gives one transfer per cycle, no bubbles.
- **Read-after-write:** a read of the same word issued immediately after a write returns the new data. The write commits on the edge that ends its data phase, before the read's data phase.
- **Wait cycles:** while HREADYOUT = 0 the slave ignores HSEL/HTRANS/HADDR (HREADY is low bus-wide). The master must hold HWDATA stable.
- **ERROR and the next transfer:** a transfer presented during ERR1 is not accepted. The master may cancel it to IDLE during ERR2.
- **Read-only window:** reads in the RO window complete OKAY. RO_START > RO_END disables the window.

## Test plan
- **Reset:** assert HRESET asynchronously mid-cycle -> HREADYOUT = 1, HRESP = 0, HRDATA = 0 before the next edge. Release, then an IDLE transfer -> OKAY, zero wait.
- **Byte-lane write and readback (WAIT_STATES = 0):**
  - Word write 0x040 = 32'hAABBCCDD, then byte write 0x041 = 8'h11 (HWDATA = 32'h0000_1100).
  - Read 0x040 -> 32'hAABB11DD, with one-cycle data phases throughout.
- **Read-only write:** write 0x004 with 32'hDEADBEEF.
  - Response: ERR1 (HREADYOUT = 0, HRESP = 1), then ERR2 (1, 1).
  - Read 0x004 afterwards -> OKAY with unchanged contents.
- **Misalignment:** halfword write to 0x101 -> two-cycle ERROR, no write. Word write to 0x102 -> two-cycle ERROR.
- **Wait states (WAIT_STATES = 3):**
  - Read 0x040 -> HREADYOUT low for exactly 3 cycles, then high with 32'hAABB11DD.
  - Back-to-back writes 0x080, 0x084 -> each completes after 3 waits. HWDATA for 0x080 held through its waits is committed.
- **Pipelined RAW:** write 0x200 = 32'h12345678 immediately followed by a read of 0x200 -> read data phase returns 32'h12345678 with no inserted wait.
